div_issue_ctrl: RTL and testbench
=================================

# div_issue_ctrl

Multi-cycle issue/capture controller in the EX stage, directly upstream of the combinational 32-bit by 8-bit divider. It latches the dividend, divisor and destination register when ID/EX issues a divide, and holds the divider inputs stable for a fixed settle window while stalling the pipeline. It then captures quotient and remainder into registers for EX/MEM and signals completion with a one-cycle `done` pulse. The divider's long combinational path therefore becomes a declared multicycle path instead of limiting the core clock.

## Interface
- `LAT`, default 4: divider settle cycles; legal range 1..15.
- `clk` input 1: core clock; all state changes on the rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `start` input 1: divide instruction valid from ID/EX.
- `op_a` input 32: dividend.
- `op_b` input 8: divisor.
- `dest` input 5: destination register number.
- `flush` input 1: cancels any in-flight divide.
- `div_a` output 32: registered dividend driven to the divider's dividend input.
- `div_b` output 8: registered divisor driven to the divider's divisor input.
- `div_q` input 32: quotient from the divider.
- `div_r` input 32: remainder from the divider.
- `stall` output 1: freezes IF/ID/EX.
- `done` output 1: one-cycle completion pulse.
- `quo` output 32: captured quotient.
- `rem` output 32: captured remainder.
- `wdest` output 5: destination register belonging to `quo`/`rem`.
- `dz` output 1: divide-by-zero flag, qualified by `done`.

## Operation
- States: IDLE, CALC, DONE. A 4-bit down-counter `cnt` runs during CALC.
- **Reset (`resetn`=0):** asynchronously forces state IDLE, `cnt`=0 and every output to 0 (`div_a`, `div_b`, `quo`, `rem`, `wdest`, `stall`, `done`, `dz`).
- **IDLE, `start`=1, no flush:** latch `op_a`, `op_b` and `dest` into `div_a`, `div_b` and the pending-destination register. Load `cnt`=LAT-1 and go to CALC.
- **CALC:** `div_a`/`div_b` are held constant. Each cycle:
  - if `cnt`≠0, decrement `cnt`;
  - if `cnt`=0, capture `div_q`→`quo`, `div_r`→`rem`, pending destination→`wdest`, clear `dz`, and go to DONE.
  - `start` is ignored in CALC.
- **DONE:** `done`=1 for exactly this cycle.
  - `start`=1 is accepted exactly as in IDLE (back-to-back divides) and the next state is CALC.
  - Otherwise the next state is IDLE.
- **Flush:** `flush`=1 in any state forces the next state to IDLE.
  - No capture occurs.
  - `quo`, `rem`, `wdest` and `dz` keep their previous values.
  - `flush` has priority over `start` in the same cycle.
- **Combinational outputs:**
  - `stall` = (state==CALC) | (start & (state!=CALC) & !flush).
  - `done` = (state==DONE).
- **Output hold:** `quo`, `rem` and `wdest` hold their values until the next capture and are valid from the DONE cycle onward.
- **Widths:** no width conversion. `div_b` is the 8-bit divisor as issued, and `rem` is the full 32-bit remainder as delivered by the divider.

## Timing
- `start` is sampled high in cycle 0.
- The operands appear on `div_a`/`div_b` from cycle 1.
- CALC occupies cycles 1..LAT, and capture happens at the end of cycle LAT.
- `done` is high in cycle LAT+1.
- `stall` is high in cycles 0..LAT and low in cycle LAT+1.
- The earliest back-to-back `start` is in cycle LAT+1, and its `done` is in cycle 2·LAT+2.
- The path from `div_a`/`div_b` to `quo`/`rem` is a LAT-cycle multicycle path. The path from `op_*` to `div_*` is single-cycle.
- Reset asserted mid-operation returns the block to IDLE immediately, with no `done` pulse.

## Configuration
- `DIV_ZERO_CHK_EN` defined:
  - A `start` accepted with `op_b`==0 bypasses CALC and goes straight to DONE on the next edge.
  - On that edge it captures `quo`=32'hFFFF_FFFF, `rem`=`op_a` and `wdest`=`dest`, and sets `dz`=1.
  - `done` is high in cycle 1, and `stall` is high only in cycle 0.
- `DIV_ZERO_CHK_EN` undefined:
  - No zero check; a zero divisor takes the normal LAT-cycle path with whatever values the divider produces.
  - `dz` is tied to 0.

## Test plan
- **Basic divide:** LAT=4, `op_a`=100, `op_b`=7, `dest`=5, `start` in cycle 0 → `stall` high in cycles 0–4; `done` in cycle 5 with `quo`=14, `rem`=2, `wdest`=5, `dz`=0.
- **Back-to-back:** divide 0xFFFF_FFFF/255 with `start` in cycle 0, then 1000/10 with `start` in cycle 5 → `done` in cycle 5 with `quo`=0x0101_0101, `rem`=0; `done` in cycle 10 with `quo`=100, `rem`=0.
- **Flush:** flush in cycle 2 of a 100/7 divide → no `done` pulse; `stall` is 0 from cycle 3; `quo`/`rem`/`wdest` keep their prior values.
- **Ignored start:** `start` pulsed in cycles 2 and 3 with different operands → ignored; `div_a`/`div_b` stay 100/7 and the result is unchanged.
- **Divide by zero (macro defined):** `op_a`=1234, `op_b`=0 → `done` and `dz` high in cycle 1 with `quo`=32'hFFFF_FFFF, `rem`=1234.
- **Reset mid-operation:** `resetn` low in cycle 3 → all outputs 0 immediately; a new `start` issued after release completes normally in LAT+1 cycles.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - issue/capture controller for the multicycle 32/8 divider
// Optional zero-divisor fast path: define DIV_ZERO_CHK_EN.
module div_issue_ctrl #(
  parameter int unsigned LAT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [7:0]  op_b,
  input  logic [4:0]  dest,
  input  logic        flush,
  output logic [31:0] div_a,
  output logic [7:0]  div_b,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  output logic        stall,
  output logic        done,
  output logic [31:0] quo,
  output logic [31:0] rem,
  output logic [4:0]  wdest,
  output logic        dz
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] div_a_q, div_a_d;
  logic [7:0]  div_b_q, div_b_d;
  logic [4:0]  pdest_q, pdest_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [4:0]  wdest_q, wdest_d;
  logic        dz_q, dz_d;
  logic        accept;

  assign accept = start & ~flush & (state_q != CALC);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_a_d = div_a_q;
    div_b_d = div_b_q;
    pdest_d = pdest_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    wdest_d = wdest_q;
    dz_d    = dz_q;
    if (flush) begin
      // Flush discards the in-flight op; captured results stay untouched.
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        CALC: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            quo_d   = div_q;
            rem_d   = div_r;
            wdest_d = pdest_q;
            dz_d    = 1'b0;
            state_d = DONE;
          end
        end
        default: begin
          state_d = IDLE;
          if (accept) begin
            div_a_d = op_a;
            div_b_d = op_b;
            pdest_d = dest;
`ifdef DIV_ZERO_CHK_EN
            if (op_b == 8'd0) begin
              quo_d   = 32'hFFFF_FFFF;
              rem_d   = op_a;
              wdest_d = dest;
              dz_d    = 1'b1;
              state_d = DONE;
            end else begin
              cnt_d   = 4'(LAT - 1);
              state_d = CALC;
            end
`else
            cnt_d   = 4'(LAT - 1);
            state_d = CALC;
`endif
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      div_a_q <= 32'd0;
      div_b_q <= 8'd0;
      pdest_q <= 5'd0;
      quo_q   <= 32'd0;
      rem_q   <= 32'd0;
      wdest_q <= 5'd0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_a_q <= div_a_d;
      div_b_q <= div_b_d;
      pdest_q <= pdest_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      wdest_q <= wdest_d;
      dz_q    <= dz_d;
    end
  end

  // stall is gated by resetn so it reads 0 while reset is held, even with start high.
  assign stall = resetn & ((state_q == CALC) | (start & (state_q != CALC) & ~flush));
  assign done  = (state_q == DONE);
  assign div_a = div_a_q;
  assign div_b = div_b_q;
  assign quo   = quo_q;
  assign rem   = rem_q;
  assign wdest = wdest_q;
`ifdef DIV_ZERO_CHK_EN
  assign dz    = dz_q;
`else
  assign dz    = 1'b0;
  logic unused_dz;
  assign unused_dz = dz_q;
`endif

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - directed self-checking bench for div_issue_ctrl
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [31:0] op_a;
  logic [7:0]  op_b;
  logic [4:0]  dest;
  logic        flush;
  logic [31:0] div_a;
  logic [7:0]  div_b;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic        stall;
  logic        done;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [4:0]  wdest;
  logic        dz;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // External combinational divider
  assign div_q = (div_b == 8'd0) ? 32'hFFFF_FFFF : div_a / {24'd0, div_b};
  assign div_r = (div_b == 8'd0) ? div_a : div_a % {24'd0, div_b};

  div_issue_ctrl #(.LAT(4)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op_a(op_a), .op_b(op_b),
    .dest(dest), .flush(flush), .div_a(div_a), .div_b(div_b), .div_q(div_q),
    .div_r(div_r), .stall(stall), .done(done), .quo(quo), .rem(rem),
    .wdest(wdest), .dz(dz)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input string tag, input logic exp_stall, input logic exp_done);
    @(negedge clk);
    check({tag, ".stall"}, 32'(stall), 32'(exp_stall));
    check({tag, ".done"}, 32'(done), 32'(exp_done));
  endtask

  task automatic issue(input logic [31:0] a, input logic [7:0] b, input logic [4:0] d);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    dest  = d;
  endtask

  task automatic check_result(input string tag, input logic [31:0] q, input logic [31:0] r,
                              input logic [4:0] w, input logic z);
    check({tag, ".quo"}, quo, q);
    check({tag, ".rem"}, rem, r);
    check({tag, ".wdest"}, 32'(wdest), 32'(w));
    check({tag, ".dz"}, 32'(dz), 32'(z));
  endtask

  initial begin
    resetn = 1'b0; start = 1'b1; op_a = 32'd0; op_b = 8'd0; dest = 5'd0; flush = 1'b0;
    sample("rst", 1'b0, 1'b0);
    check("rst.div_a", div_a, 32'd0);
    check("rst.div_b", 32'(div_b), 32'd0);
    check_result("rst", 32'd0, 32'd0, 5'd0, 1'b0);
    start = 1'b0;
    tick();
    resetn = 1'b1;
    tick();

    // Basic divide
    issue(32'd100, 8'd7, 5'd5);
    sample("basic.c0", 1'b1, 1'b0); tick();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      sample("basic.calc", 1'b1, 1'b0);
      if (c == 1) begin
        check("basic.div_a", div_a, 32'd100);
        check("basic.div_b", 32'(div_b), 32'd7);
      end
      tick();
    end
    sample("basic.c5", 1'b0, 1'b1);
    check_result("basic", 32'd14, 32'd2, 5'd5, 1'b0);
    tick();
    sample("basic.c6", 1'b0, 1'b0);
    check("basic.hold", quo, 32'd14);
    tick();

    // Back-to-back
    issue(32'hFFFF_FFFF, 8'd255, 5'd1);
    sample("b2b.c0", 1'b1, 1'b0); tick();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin sample("b2b.calc1", 1'b1, 1'b0); tick(); end
    issue(32'd1000, 8'd10, 5'd2);
    sample("b2b.c5", 1'b1, 1'b1);
    check_result("b2b.r1", 32'h0101_0101, 32'd0, 5'd1, 1'b0);
    tick();
    start = 1'b0;
    for (int c = 6; c <= 9; c++) begin sample("b2b.calc2", 1'b1, 1'b0); tick(); end
    sample("b2b.c10", 1'b0, 1'b1);
    check_result("b2b.r2", 32'd100, 32'd0, 5'd2, 1'b0);
    tick();

    // Flush mid-calc
    issue(32'd100, 8'd7, 5'd9);
    sample("flush.c0", 1'b1, 1'b0); tick();
    start = 1'b0;
    sample("flush.c1", 1'b1, 1'b0); tick();
    flush = 1'b1;
    sample("flush.c2", 1'b1, 1'b0); tick();
    flush = 1'b0;
    for (int c = 3; c <= 7; c++) begin sample("flush.idle", 1'b0, 1'b0); tick(); end
    check_result("flush.keep", 32'd100, 32'd0, 5'd2, 1'b0);

    // Flush beats start in IDLE
    issue(32'd50, 8'd5, 5'd4);
    flush = 1'b1;
    sample("prio.c0", 1'b0, 1'b0); tick();
    start = 1'b0; flush = 1'b0;
    sample("prio.c1", 1'b0, 1'b0);
    check("prio.div_a", div_a, 32'd100);
    tick();

    // Starts during CALC are ignored
    issue(32'd100, 8'd7, 5'd7);
    sample("ign.c0", 1'b1, 1'b0); tick();
    start = 1'b0;
    sample("ign.c1", 1'b1, 1'b0); tick();
    issue(32'd50, 8'd3, 5'd8);
    sample("ign.c2", 1'b1, 1'b0); tick();
    issue(32'd60, 8'd4, 5'd9);
    sample("ign.c3", 1'b1, 1'b0);
    check("ign.div_a", div_a, 32'd100);
    check("ign.div_b", 32'(div_b), 32'd7);
    tick();
    start = 1'b0;
    sample("ign.c4", 1'b1, 1'b0); tick();
    sample("ign.c5", 1'b0, 1'b1);
    check_result("ign", 32'd14, 32'd2, 5'd7, 1'b0);
    tick();

    // Zero divisor
    issue(32'd1234, 8'd0, 5'd3);
    sample("dz.c0", 1'b1, 1'b0); tick();
    start = 1'b0;
`ifdef DIV_ZERO_CHK_EN
    sample("dz.c1", 1'b0, 1'b1);
    check_result("dz", 32'hFFFF_FFFF, 32'd1234, 5'd3, 1'b1);
    tick();
    sample("dz.c2", 1'b0, 1'b0);
    tick();
`else
    for (int c = 1; c <= 4; c++) begin sample("dz.calc", 1'b1, 1'b0); tick(); end
    sample("dz.c5", 1'b0, 1'b1);
    check_result("dz", 32'hFFFF_FFFF, 32'd1234, 5'd3, 1'b0);
    tick();
`endif

    // Reset mid-operation
    issue(32'd200, 8'd9, 5'd6);
    sample("rmid.c0", 1'b1, 1'b0); tick();
    start = 1'b0;
    sample("rmid.c1", 1'b1, 1'b0); tick();
    sample("rmid.c2", 1'b1, 1'b0); tick();
    resetn = 1'b0;
    #1;
    check("rmid.stall", 32'(stall), 32'd0);
    check("rmid.done", 32'(done), 32'd0);
    check("rmid.div_a", div_a, 32'd0);
    check("rmid.div_b", 32'(div_b), 32'd0);
    check_result("rmid", 32'd0, 32'd0, 5'd0, 1'b0);
    tick();
    sample("rmid.held", 1'b0, 1'b0);
    tick();
    resetn = 1'b1;
    tick();
    issue(32'd81, 8'd9, 5'd10);
    sample("post.c0", 1'b1, 1'b0); tick();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin sample("post.calc", 1'b1, 1'b0); tick(); end
    sample("post.c5", 1'b0, 1'b1);
    check_result("post", 32'd9, 32'd0, 5'd10, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
